// File: rtl/cci_rd_arbiter.sv
// Round-robin arbiter that shares the CCI-P c0 read channel between NUM_REQ clients.
// Optional per-client grant statistics are enabled with CCI_RD_ARB_STATS_EN.
module cci_rd_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int MAX_OUTST = 32,
  parameter int ID_W      = $clog2(NUM_REQ)
) (
  input  logic                    clk,
  input  logic                    SoftReset,
  input  logic [NUM_REQ-1:0]      req_valid,
  input  logic [NUM_REQ*64-1:0]   req_addr,
  output logic [NUM_REQ-1:0]      req_ready,
  output logic [63:0]             c0_req_addr,
  output logic [15:0]             c0_req_mdata,
  output logic                    c0_req_en,
  input  logic                    c0_alm_full,
  input  logic                    c0_rsp_valid,
  input  logic [15:0]             c0_rsp_mdata,
  input  logic [511:0]            c0_rsp_data,
  output logic [NUM_REQ-1:0]      rsp_valid,
  output logic [511:0]            rsp_data,
`ifdef CCI_RD_ARB_STATS_EN
  input  logic [ID_W-1:0]         stat_sel,
  output logic [31:0]             stat_grants,
`endif
  output logic                    err
);

  localparam logic [ID_W:0] NREQ = (ID_W+1)'(NUM_REQ);
  localparam logic [7:0]    MAXO = 8'(MAX_OUTST);

  logic [ID_W-1:0]    ptr;
  logic [ID_W-1:0]    ptr_nxt;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] inc;
  logic [NUM_REQ-1:0] dec;
  logic [NUM_REQ-1:0] empty;
  logic               gnt_vld;
  logic [ID_W-1:0]    gnt_id;
  logic [ID_W:0]      idx;
  logic [ID_W:0]      nxt;
  logic [63:0]        sel_addr;
  logic [7:0]         outst [NUM_REQ];

  logic [ID_W-1:0]    rsp_id;
  logic               rsp_hi;
  logic               rsp_ok;
  logic               uflow;

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      elig[i]  = req_valid[i] && (outst[i] < MAXO)
               && !c0_alm_full && !SoftReset;
      empty[i] = (outst[i] == 8'd0);
    end
  end

  // search upward from ptr, wrapping at NUM_REQ (not a power of two in general)
  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    idx     = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      idx = {1'b0, ptr} + (ID_W+1)'(k);
      if (idx >= NREQ)
        idx = idx - NREQ;
      if (!gnt_vld && elig[idx[ID_W-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_id  = idx[ID_W-1:0];
      end
    end
  end

  always_comb begin
    nxt = {1'b0, gnt_id} + (ID_W+1)'(1);
    if (nxt >= NREQ)
      nxt = '0;
    ptr_nxt = nxt[ID_W-1:0];
  end

  always_comb begin
    sel_addr = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (gnt_id == ID_W'(i))
        sel_addr = req_addr[64*i +: 64];
  end

  assign rsp_id = c0_rsp_mdata[ID_W-1:0];
  assign rsp_hi = |c0_rsp_mdata[15:ID_W];
  assign rsp_ok = c0_rsp_valid && !rsp_hi
                && ({1'b0, rsp_id} < NREQ);

  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      inc[i] = gnt_vld && (gnt_id == ID_W'(i));
      dec[i] = rsp_ok && (rsp_id == ID_W'(i));
    end
  end

  assign req_ready = inc;
  assign uflow     = |(dec & empty);

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      ptr <= '0;
      err <= 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
        outst[i] <= 8'd0;
    end else begin
      if (gnt_vld)
        ptr <= ptr_nxt;
      if ((c0_rsp_valid && !rsp_ok) || uflow)
        err <= 1'b1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (inc[i] && !dec[i])
          outst[i] <= outst[i] + 8'd1;
        else if (dec[i] && !inc[i] && !empty[i])
          outst[i] <= outst[i] - 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      c0_req_en    <= 1'b0;
      c0_req_addr  <= '0;
      c0_req_mdata <= '0;
      rsp_valid    <= '0;
      rsp_data     <= '0;
    end else begin
      c0_req_en <= gnt_vld;
      if (gnt_vld) begin
        c0_req_addr  <= sel_addr;
        c0_req_mdata <= {{(16-ID_W){1'b0}}, gnt_id};
      end
      rsp_valid <= dec;
      if (rsp_ok)
        rsp_data <= c0_rsp_data;
    end
  end

`ifdef CCI_RD_ARB_STATS_EN
  logic [31:0] gcnt [NUM_REQ];
  logic [31:0] gsel;

  always_comb begin
    gsel = '0;
    for (int i = 0; i < NUM_REQ; i++)
      if (stat_sel == ID_W'(i))
        gsel = gcnt[i];
  end

  always_ff @(posedge clk) begin
    if (SoftReset) begin
      stat_grants <= '0;
      for (int i = 0; i < NUM_REQ; i++)
        gcnt[i] <= '0;
    end else begin
      stat_grants <= gsel;
      for (int i = 0; i < NUM_REQ; i++)
        if (inc[i])
          gcnt[i] <= gcnt[i] + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cci_rd_arbiter.sv
// Scoreboard bench for cci_rd_arbiter (NUM_REQ=4, MAX_OUTST=2).
// Build with CCI_RD_ARB_STATS_EN defined to also cover the grant statistics.
module tb_cci_rd_arbiter;

  localparam int N = 4;

  logic           clk = 1'b0;
  logic           SoftReset;
  logic [N-1:0]   req_valid;
  logic [N*64-1:0] req_addr;
  logic [N-1:0]   req_ready;
  logic [63:0]    c0_req_addr;
  logic [15:0]    c0_req_mdata;
  logic           c0_req_en;
  logic           c0_alm_full;
  logic           c0_rsp_valid;
  logic [15:0]    c0_rsp_mdata;
  logic [511:0]   c0_rsp_data;
  logic [N-1:0]   rsp_valid;
  logic [511:0]   rsp_data;
  logic           err;
`ifdef CCI_RD_ARB_STATS_EN
  logic [1:0]     stat_sel;
  logic [31:0]    stat_grants;
`endif

  always #5 clk = ~clk;

  cci_rd_arbiter #(.NUM_REQ(N), .MAX_OUTST(2)) dut (
    .clk(clk), .SoftReset(SoftReset),
    .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
    .c0_req_addr(c0_req_addr), .c0_req_mdata(c0_req_mdata),
    .c0_req_en(c0_req_en), .c0_alm_full(c0_alm_full),
    .c0_rsp_valid(c0_rsp_valid), .c0_rsp_mdata(c0_rsp_mdata),
    .c0_rsp_data(c0_rsp_data), .rsp_valid(rsp_valid),
    .rsp_data(rsp_data),
`ifdef CCI_RD_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_grants(stat_grants),
`endif
    .err(err)
  );

  typedef struct {
    logic [63:0] a;
    logic [15:0] m;
  } req_t;

  typedef struct {
    logic [N-1:0]  v;
    logic [511:0]  d;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];
  req_t mr;
  rsp_t ms;
  int   total = 0;
  int   bad = 0;

  logic [511:0] d_a5;
  logic [511:0] d_1;
  logic [511:0] d_2;

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_req(input int id);
    req_t r;
    r.a = 64'(32'h1000 * (id + 1));
    r.m = 16'(id);
    exp_req.push_back(r);
  endtask

  task automatic push_rsp(input logic [N-1:0] v, input logic [511:0] d);
    rsp_t r;
    r.v = v;
    r.d = d;
    exp_rsp.push_back(r);
  endtask

  task automatic send_rsp(input logic [15:0] m, input logic [511:0] d);
    c0_rsp_valid = 1'b1;
    c0_rsp_mdata = m;
    c0_rsp_data  = d;
    tick(1);
    c0_rsp_valid = 1'b0;
  endtask

  task automatic do_reset;
    SoftReset = 1'b1;
    tick(1);
    SoftReset = 1'b0;
    tick(1);
  endtask

  always @(negedge clk) begin
    if (c0_req_en === 1'b1) begin
      if (exp_req.size() == 0) begin
        total++;
        bad++;
        $display("FAIL req_unexp act=%0h/%0h exp=none",
                 c0_req_mdata, c0_req_addr);
      end else begin
        mr = exp_req.pop_front();
        chk("req_addr", 512'(c0_req_addr), 512'(mr.a));
        chk("req_mdata", 512'(c0_req_mdata), 512'(mr.m));
      end
    end
    if (rsp_valid !== '0 && !$isunknown(rsp_valid)) begin
      if (exp_rsp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rsp_unexp act=%b exp=none", rsp_valid);
      end else begin
        ms = exp_rsp.pop_front();
        chk("rsp_valid", 512'(rsp_valid), 512'(ms.v));
        chk("rsp_data", rsp_data, ms.d);
      end
    end
  end

  initial begin
    d_a5 = {64{8'hA5}};
    d_1  = {16{32'h1234_5678}};
    d_2  = {16{32'hCAFE_0003}};
    for (int i = 0; i < N; i++)
      req_addr[64*i +: 64] = 64'(32'h1000 * (i + 1));
    SoftReset    = 1'b1;
    req_valid    = 4'hF;
    c0_alm_full  = 1'b0;
    c0_rsp_valid = 1'b0;
    c0_rsp_mdata = '0;
    c0_rsp_data  = '0;
`ifdef CCI_RD_ARB_STATS_EN
    stat_sel = '0;
`endif
    tick(2);
    @(negedge clk);
    chk("rst_ready", 512'(req_ready), 512'(0));
    chk("rst_en", 512'(c0_req_en), 512'(0));
    chk("rst_addr", 512'(c0_req_addr), 512'(0));
    chk("rst_mdata", 512'(c0_req_mdata), 512'(0));
    chk("rst_rspv", 512'(rsp_valid), 512'(0));
    chk("rst_rspd", rsp_data, 512'(0));
    chk("rst_err", 512'(err), 512'(0));
    req_valid = '0;
    SoftReset = 1'b0;
    tick(1);

    // round robin until every client holds its two credits
    for (int i = 0; i < 8; i++)
      push_req(i % 4);
    req_valid = 4'hF;
    @(negedge clk);
    chk("rr_ready_first", 512'(req_ready), 512'(4'b0001));
    tick(11);
    @(negedge clk);
    chk("rr_ready_sat", 512'(req_ready), 512'(0));
    req_valid = '0;
    tick(2);
    chk("rr_drain", 512'(exp_req.size()), 512'(0));

    // almost full holds the pointer
    do_reset;
    push_req(0);
    req_valid = 4'b0001;
    tick(1);
    req_valid   = 4'hF;
    c0_alm_full = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("af_ready", 512'(req_ready), 512'(0));
      tick(1);
    end
    c0_alm_full = 1'b0;
    push_req(1);
    @(negedge clk);
    chk("af_resume", 512'(req_ready), 512'(4'b0010));
    tick(1);
    req_valid = '0;
    tick(2);
    chk("af_drain", 512'(exp_req.size()), 512'(0));

    // credit limit on client 1
    do_reset;
    push_req(1);
    push_req(1);
    req_valid = 4'b0010;
    tick(6);
    @(negedge clk);
    chk("cr_ready_sat", 512'(req_ready), 512'(0));
    push_rsp(4'b0010, d_1);
    push_req(1);
    send_rsp(16'h0001, d_1);
    tick(5);
    @(negedge clk);
    chk("cr_ready_sat2", 512'(req_ready), 512'(0));
    req_valid = '0;
    tick(2);
    chk("cr_drain", 512'(exp_req.size()), 512'(0));
    chk("cr_err", 512'(err), 512'(0));

    // routing and malformed mdata
    do_reset;
    push_req(2);
    req_valid = 4'b0100;
    tick(1);
    req_valid = '0;
    push_rsp(4'b0100, d_a5);
    send_rsp(16'h0002, d_a5);
    tick(1);
    @(negedge clk);
    chk("rt_err0", 512'(err), 512'(0));
    send_rsp(16'h0010, d_1);
    tick(2);
    @(negedge clk);
    chk("rt_err1", 512'(err), 512'(1));

    // grant and response to client 3 in the same cycle
    do_reset;
    chk("rst_err_clr", 512'(err), 512'(0));
    push_req(3);
    push_req(3);
    push_req(3);
    req_valid = 4'b1000;
    tick(1);
    push_rsp(4'b1000, d_2);
    send_rsp(16'h0003, d_2);
    tick(5);
    @(negedge clk);
    chk("sim_ready", 512'(req_ready), 512'(0));
    req_valid = '0;
    tick(2);
    chk("sim_err", 512'(err), 512'(0));
    chk("sim_drain", 512'(exp_req.size()), 512'(0));

    // stale response after reset
    do_reset;
    push_rsp(4'b1000, d_2);
    send_rsp(16'h0003, d_2);
    tick(1);
    @(negedge clk);
    chk("stale_err", 512'(err), 512'(1));

`ifdef CCI_RD_ARB_STATS_EN
    do_reset;
    for (int i = 0; i < 10; i++) begin
      push_req(2);
      push_rsp(4'b0100, d_1);
      req_valid = 4'b0100;
      tick(1);
      req_valid = '0;
      send_rsp(16'h0002, d_1);
    end
    stat_sel = 2'd2;
    tick(1);
    @(negedge clk);
    chk("st_cnt", 512'(stat_grants), 512'(10));
    chk("st_err", 512'(err), 512'(0));
    do_reset;
    @(negedge clk);
    chk("st_rst", 512'(stat_grants), 512'(0));
`endif

    tick(3);
    chk("fin_req_q", 512'(exp_req.size()), 512'(0));
    chk("fin_rsp_q", 512'(exp_rsp.size()), 512'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/cci_rd_arbiter.md
Name: cci_rd_arbiter

Overview:
- Shares the single CCI-P c0 read-request channel between NUM_REQ independent read clients, for example the nodes, edges, distance and worklist readers of the BFS system.
- Arbitrates round-robin, tags each request's mdata with the client ID, and enforces a per-client outstanding-request credit limit.
- Honours c0TxAlmFull and steers each read response back to its owning client using the returned mdata.
- Sits between the client read engines and the c0 header register stage in the top-level system.

Parameters:
- NUM_REQ, 4, number of read clients (2..16).
- MAX_OUTST, 32, maximum outstanding reads per client (1..255).
- ID_W, $clog2(NUM_REQ), width of the client ID field in mdata (derived; do not override).

Ports:
- clk  in  1  system clock.
- SoftReset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-client request valid.
- req_addr  in  NUM_REQ*64  per-client cache-line address; client i occupies bits [64*i+63:64*i].
- req_ready  out  NUM_REQ  per-client accept; combinational one-hot grant.
- c0_req_addr  out  64  address to the c0 header.
- c0_req_mdata  out  16  mdata to the c0 header.
- c0_req_en  out  1  request valid toward the c0 register stage.
- c0_alm_full  in  1  cp2af_sRx.c0TxAlmFull.
- c0_rsp_valid  in  1  read-data response valid (MMIO responses already excluded upstream).
- c0_rsp_mdata  in  16  response mdata.
- c0_rsp_data  in  512  response data.
- rsp_valid  out  NUM_REQ  one-hot response strobe to clients.
- rsp_data  out  512  response data, shared by all clients.
- err  out  1  sticky protocol-error flag.

Behaviour:
- Reset (SoftReset=1 at a clk edge):
  - c0_req_en=0, c0_req_addr=0, c0_req_mdata=0, rsp_valid=0, rsp_data=0, err=0.
  - All outstanding counters cleared to 0; round-robin pointer set to 0.
  - req_ready=0 for the whole cycle in which SoftReset is high.
- Eligibility: client i is eligible when req_valid[i]=1, outst[i]<MAX_OUTST and c0_alm_full=0.
- Arbitration:
  - Grant the first eligible client searching from the pointer upward, wrapping modulo NUM_REQ.
  - At most one grant per cycle; req_ready[grant]=1 in the same cycle.
  - On a grant, the pointer moves to grant+1 (mod NUM_REQ). With no grant, the pointer holds.
- Request output (registered, latency 1):
  - The cycle after a grant: c0_req_en=1, c0_req_addr=req_addr[grant], c0_req_mdata = {(16-ID_W) zeros, grant ID}.
  - With no grant, c0_req_en=0; addr and mdata hold their last values.
- Back-pressure:
  - c0_alm_full=1 blocks all grants that cycle.
  - A request granted in the same cycle that c0_alm_full rises is still issued; CCI-P almost-full slack covers it.
- Outstanding counters (8-bit each):
  - Increment on grant; decrement on a routed response to that client.
  - Grant and response for the same client in the same cycle leave the count unchanged.
  - Saturate at MAX_OUTST (guaranteed by eligibility) and never underflow.
- Response routing (registered, latency 1):
  - On c0_rsp_valid, id = c0_rsp_mdata[ID_W-1:0].
  - If id<NUM_REQ: rsp_valid[id]=1 and rsp_data=c0_rsp_data on the next cycle.
  - If id>=NUM_REQ, or c0_rsp_mdata[15:ID_W] is nonzero: the response is dropped and err is set.
- Underflow: a response for a client whose outst is 0 (for example a stale response after reset) is still forwarded, the counter stays 0, and err is set.
- err stays set until SoftReset.
- No response FIFO: clients accept rsp_valid unconditionally.

Optional Feature:
- Macro CCI_RD_ARB_STATS_EN.
- When defined, adds two ports:
  - stat_sel  in  ID_W  client select.
  - stat_grants  out  32  grant count for client stat_sel.
- Counters are per client, 32 bits, wrap at 2^32, cleared by SoftReset; stat_grants is the registered value, latency 1 from stat_sel.
- When undefined, neither the ports nor the counters exist, and the remaining behaviour is identical.

Test Plan:
- Round robin: NUM_REQ=4, all req_valid=1, addresses 0x1000*(i+1), c0_alm_full=0 → c0_req_mdata sequence 0,1,2,3,0,… with matching addresses, one request per cycle, c0_req_en held high.
- Almost full: c0_alm_full=1 for 5 cycles with all clients requesting → req_ready=0 and c0_req_en=0 from the second blocked cycle; after deassertion, arbitration resumes at the held pointer.
- Credit limit: MAX_OUTST=2, client 1 alone requesting, no responses → exactly 2 grants; a response with mdata=0x0001 → 1 further grant; outst[1]=2.
- Routing: response with mdata=0x0002 and data=0xA5…A5 → rsp_valid=4'b0100 and rsp_data=0xA5…A5 one cycle later; a response with mdata=0x0010 → no rsp_valid, err=1.
- Simultaneous events: a grant to client 3 and a response for client 3 in the same cycle → outst[3] unchanged; a stale response after SoftReset → forwarded and err=1.
- Stats (CCI_RD_ARB_STATS_EN defined): 10 grants to client 2 → stat_sel=2 gives stat_grants=10 one cycle later; SoftReset → 0.
